// File: rtl/pci_sys_pkg.sv
// Shared command codes, FSM state type and default data width for the
// PCI-to-system command bridge.
package pci_sys_pkg;

    localparam int unsigned PCI_DATA_W = 32;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWrData,
        StRdReq,
        StRdData
    } state_e;

endpackage

// File: rtl/pci_sys_cmd_bridge.sv
// sys_clk-side bridge: decodes PCI memory commands, turns write bursts into
// system write beats and read commands into one read request plus a response burst.
module pci_sys_cmd_bridge
    import pci_sys_pkg::*;
#(
    parameter int unsigned DATA_W    = PCI_DATA_W,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    input  logic [3:0]        cmd,
    input  logic              rfifo_empty,
    input  logic [DATA_W-1:0] pci_read_data,
    output logic              rfifo_pop,
    input  logic              wfifo_full,
    output logic              wfifo_push,
    output logic [DATA_W-1:0] pci_write_data,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [DATA_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_data,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [7:0]        bad_cmd_cnt
);

    state_e            state_q;
    logic [3:0]        cmd_q;
    logic [DATA_W-1:0] base_q;
    logic [CNT_W-1:0]  beat_q;
    logic [7:0]        bad_cnt_q;
    logic              last_beat;

    assign last_beat   = (beat_q == CNT_W'(BURST_LEN - 1));
    assign busy        = (state_q != StIdle);
    assign bad_cmd_cnt = bad_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            base_q    <= '0;
            beat_q    <= '0;
            bad_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        cmd_q   <= cmd;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (!rfifo_empty) begin
                        beat_q <= '0;
                        if (cmd_q == CMD_MEM_WR) begin
                            base_q  <= pci_read_data;
                            state_q <= StWrData;
                        end else if (cmd_q == CMD_MEM_RD) begin
                            base_q  <= pci_read_data;
                            state_q <= StRdReq;
                        end else begin
                            // Unsupported: address word is consumed and dropped.
                            state_q <= StIdle;
                            if (bad_cnt_q != 8'hFF) begin
                                bad_cnt_q <= bad_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                StWrData: begin
                    if (!rfifo_empty && req_ready) begin
                        if (last_beat) begin
                            beat_q  <= '0;
                            state_q <= StIdle;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StRdReq: begin
                    if (req_ready) begin
                        beat_q  <= '0;
                        state_q <= StRdData;
                    end
                end
                StRdData: begin
                    if (rsp_valid && !wfifo_full) begin
                        if (last_beat) begin
                            beat_q  <= '0;
                            state_q <= StIdle;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes are pass-through so a handshake and its FIFO pop share one cycle.
    always_comb begin
        rfifo_pop      = 1'b0;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_addr       = '0;
        req_data       = '0;
        rsp_ready      = 1'b0;
        wfifo_push     = 1'b0;
        pci_write_data = '0;
        unique case (state_q)
            StAddr: rfifo_pop = !rfifo_empty;
            StWrData: begin
                req_valid = !rfifo_empty;
                req_write = 1'b1;
                req_data  = pci_read_data;
                req_addr  = base_q + (DATA_W'(beat_q) << 2);
                rfifo_pop = !rfifo_empty && req_ready;
            end
            StRdReq: begin
                req_valid = 1'b1;
                req_addr  = base_q;
            end
            StRdData: begin
                rsp_ready      = !wfifo_full;
                wfifo_push     = rsp_valid && !wfifo_full;
                pci_write_data = rsp_data;
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    cmd_while_busy: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        !(cmd_valid && state_q != StIdle));
`endif

endmodule

// File: tb/tb_pci_sys_cmd_bridge.sv
// Scoreboard bench for pci_sys_cmd_bridge: models the PCI read FIFO and
// checks system request beats and write-FIFO pushes against queued expectations.
module tb_pci_sys_cmd_bridge;
    import pci_sys_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned BL = 8;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n, cmd_valid, rfifo_empty, rfifo_pop, wfifo_full, wfifo_push;
    logic [3:0]    cmd;
    logic [DW-1:0] pci_read_data, pci_write_data, req_addr, req_data, rsp_data;
    logic          req_valid, req_ready, req_write, rsp_valid, rsp_ready, busy;
    logic [7:0]    bad_cmd_cnt;

    logic [DW-1:0] rmem [1024];
    logic [9:0]    rd_ptr = '0;
    logic [9:0]    wr_ptr = '0;
    logic          stall_empty = 1'b0;
    bit            rand_bp = 1'b0;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   pop_cnt  = 0;
    int   push_cnt = 0;
    int   rv_cnt   = 0;
    bit   rsp_hs   = 1'b0;
    req_t exp_req[$];
    logic [DW-1:0] exp_wf[$];

    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_addr, prev_data;

    always #5 sys_clk = ~sys_clk;

    assign rfifo_empty   = (rd_ptr == wr_ptr) || stall_empty;
    assign pci_read_data = rmem[rd_ptr];

    pci_sys_cmd_bridge #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(4)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .cmd_valid      (cmd_valid),
        .cmd            (cmd),
        .rfifo_empty    (rfifo_empty),
        .pci_read_data  (pci_read_data),
        .rfifo_pop      (rfifo_pop),
        .wfifo_full     (wfifo_full),
        .wfifo_push     (wfifo_push),
        .pci_write_data (pci_write_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .busy           (busy),
        .bad_cmd_cnt    (bad_cmd_cnt)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge sys_clk) begin
        if (rfifo_pop) begin
            rd_ptr  <= rd_ptr + 10'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    // Monitor samples mid-cycle, when inputs and combinational outputs are settled.
    always @(negedge sys_clk) begin
        req_t e;
        rsp_hs = rsp_valid && rsp_ready;
        if (req_valid) rv_cnt++;
        if (rfifo_pop && rfifo_empty) check("pop_while_empty", 1, 0);
        if (wfifo_push && wfifo_full) check("push_while_full", 1, 0);
        if (wfifo_full && rsp_ready) check("rsp_ready_while_full", 1, 0);
        if (prev_stall && req_valid) begin
            check("stable_addr", req_addr, prev_addr);
            check("stable_data", req_data, prev_data);
        end
        prev_stall = req_valid && !req_ready;
        prev_addr  = req_addr;
        prev_data  = req_data;
        if (req_valid && req_ready) begin
            if (exp_req.size() == 0) begin
                check("req_extra", 1, 0);
            end else begin
                e = exp_req.pop_front();
                check("req_write", {31'd0, req_write}, {31'd0, e.wr});
                check("req_addr", req_addr, e.addr);
                if (e.wr) check("req_data", req_data, e.data);
            end
        end
        if (wfifo_push) begin
            push_cnt++;
            if (exp_wf.size() == 0) check("wfifo_extra", 1, 0);
            else check("wfifo_data", pci_write_data, exp_wf.pop_front());
        end
    end

    task automatic push_rfifo(input logic [DW-1:0] w);
        rmem[wr_ptr] = w;
        wr_ptr = wr_ptr + 10'd1;
    endtask

    task automatic pulse_cmd(input logic [3:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 400) begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (rand_bp) begin
                req_ready   = 1'($urandom_range(0, 1));
                stall_empty = ($urandom_range(0, 3) == 0);
            end
        end
        if (busy) check("timeout_idle", 1, 0);
    endtask

    task automatic do_write(input logic [DW-1:0] base, input bit bp);
        int   p0, cyc;
        req_t e;
        p0 = pop_cnt;
        push_rfifo(base);
        for (int i = 0; i < BL; i++) begin
            e.wr   = 1'b1;
            e.addr = base + DW'(i * 4);
            e.data = $urandom;
            push_rfifo(e.data);
            exp_req.push_back(e);
        end
        rand_bp = bp;
        pulse_cmd(CMD_MEM_WR);
        wait_idle(cyc);
        rand_bp     = 1'b0;
        req_ready   = 1'b1;
        stall_empty = 1'b0;
        check("wr_pops", DW'(pop_cnt - p0), DW'(BL + 1));
        check("wr_left", DW'(exp_req.size()), 0);
        if (!bp) check("wr_latency", DW'(cyc), DW'(BL + 1));
    endtask

    task automatic do_bad(input logic [3:0] c);
        int p0, cyc;
        p0 = pop_cnt;
        push_rfifo($urandom);
        pulse_cmd(c);
        wait_idle(cyc);
        check("bad_pops", DW'(pop_cnt - p0), 1);
    endtask

    // Starts a read burst; stops early (returning) once stop_after pushes are seen.
    task automatic do_read(input logic [DW-1:0] base, input int stop_after, input bit bp);
        int            p0, q0, cyc, idx;
        req_t          e;
        logic [DW-1:0] words [BL];
        p0 = pop_cnt;
        q0 = push_cnt;
        push_rfifo(base);
        e.wr   = 1'b0;
        e.addr = base;
        e.data = '0;
        exp_req.push_back(e);
        for (int i = 0; i < BL; i++) begin
            words[i] = 32'hA0 + DW'(i);
            exp_wf.push_back(words[i]);
        end
        idx       = 0;
        req_ready = !bp;
        rsp_valid = 1'b1;
        rsp_data  = words[0];
        pulse_cmd(CMD_MEM_RD);
        cyc = 0;
        while (busy && cyc < 400 && (push_cnt - q0) < stop_after) begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (rsp_hs) idx++;
            if (bp) begin
                req_ready  = (cyc >= 3);
                wfifo_full = (cyc == 8 || cyc == 11);
            end
            rsp_valid = (idx < BL);
            rsp_data  = (idx < BL) ? words[idx] : '0;
        end
        if (cyc >= 400) check("timeout_read", 1, 0);
        rsp_valid  = 1'b0;
        wfifo_full = 1'b0;
        req_ready  = 1'b1;
        check("rd_pops", DW'(pop_cnt - p0), 1);
        check("rd_req_left", DW'(exp_req.size()), 0);
    endtask

    task automatic check_all_low(input string tag);
        check(tag, {26'd0, busy, req_valid, req_write, rfifo_pop, wfifo_push, rsp_ready}, 0);
        check({tag, "_addr"}, req_addr, 0);
        check({tag, "_wdata"}, pci_write_data, 0);
        check({tag, "_badcnt"}, {24'd0, bad_cmd_cnt}, 0);
    endtask

    initial begin
        int       rv0;
        logic [3:0] c;
        sys_rst_n  = 1'b0;
        cmd_valid  = 1'b0;
        cmd        = '0;
        wfifo_full = 1'b0;
        req_ready  = 1'b1;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        check_all_low("reset");
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        do_write(32'h0000_1000, 1'b0);
        do_write(32'h0000_3000, 1'b1);

        do_read(32'h0000_2000, BL, 1'b1);
        check("rd_wfifo_left", DW'(exp_wf.size()), 0);

        rv0 = rv_cnt;
        do_bad(4'b0011);
        do_bad(4'b1111);
        check("bad_no_req", DW'(rv_cnt - rv0), 0);
        check("bad_cnt_2", {24'd0, bad_cmd_cnt}, 2);
        for (int i = 0; i < 298; i++) begin
            do c = 4'($urandom_range(0, 15)); while (c == CMD_MEM_RD || c == CMD_MEM_WR);
            do_bad(c);
        end
        check("bad_cnt_sat", {24'd0, bad_cmd_cnt}, 255);

        do_read(32'h0000_4000, 3, 1'b0);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        check_all_low("mid_reset");
        sys_rst_n = 1'b1;
        exp_wf.delete();
        @(posedge sys_clk);
        #1;

        do_write(32'h0000_5000, 1'b0);
        do_write(32'hFFFF_FFF8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pci_sys_cmd_bridge.md
Name: pci_sys_cmd_bridge

Overview:
- sys_clk-domain consumer of the PCI core's command strobe and read FIFO, and producer for its write FIFO.
- Decodes each PCI memory command, forwards write bursts to the system request bus, and issues read requests whose responses are pushed back toward PCI.
- Sits between the PCI top level and the system-side context/SDRAM logic.

Parameters:
- DATA_W, 32, width of FIFO and bus data words
- BURST_LEN, 8, data words per command (fixed-length bursts)
- CNT_W, 4, width of burst counter (must satisfy 2**CNT_W > BURST_LEN)

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  one-cycle pulse; new PCI command available on cmd
- cmd  in  4  PCI command code
- rfifo_empty  in  1  PCI→sys FIFO empty
- pci_read_data  in  DATA_W  FWFT head of PCI→sys FIFO, valid when !rfifo_empty
- rfifo_pop  out  1  consume head word this cycle
- wfifo_full  in  1  sys→PCI FIFO full
- wfifo_push  out  1  write pci_write_data this cycle
- pci_write_data  out  DATA_W  word into sys→PCI FIFO
- req_valid  out  1  system request valid
- req_ready  in  1  system request accepted
- req_write  out  1  1 = write beat, 0 = read request
- req_addr  out  DATA_W  burst base address plus beat offset ×4
- req_data  out  DATA_W  write beat data
- rsp_valid  in  1  read response word valid
- rsp_ready  out  1  bridge can accept response word
- rsp_data  in  DATA_W  read response word
- busy  out  1  state != IDLE
- bad_cmd_cnt  out  8  saturating count of unsupported commands

Behaviour:
- Reset: every output 0; state IDLE; counters 0; latched cmd/addr 0.
- Commands: 4'b0111 MEM_WR, 4'b0110 MEM_RD. Every other code is unsupported.
- A cmd_valid pulse arriving while state != IDLE is ignored. PCI core guarantees this never happens. Assertion fires in sim.
- IDLE: on cmd_valid, latch cmd and go to ADDR.
- ADDR: wait for !rfifo_empty, then pop one word (rfifo_pop=1 for exactly that cycle) and latch it as base address; beat counter 0. Next state: MEM_WR → WR_DATA; MEM_RD → RD_REQ; unsupported → IDLE with bad_cmd_cnt+1 (saturates at 255), address word discarded.
- WR_DATA:
  - req_valid = !rfifo_empty; req_write=1; req_data=pci_read_data; req_addr=base+4·beat.
  - rfifo_pop = req_valid & req_ready (combinational, same cycle as handshake).
  - Beat increments per handshake; after beat BURST_LEN-1 handshakes → IDLE.
- RD_REQ: req_valid=1, req_write=0, req_addr=base, held until req_ready. Then RD_DATA, beat 0.
- RD_DATA:
  - rsp_ready = !wfifo_full; wfifo_push = rsp_valid & rsp_ready; pci_write_data = rsp_data (combinational pass-through).
  - After BURST_LEN pushes → IDLE.
  - rsp_valid outside RD_DATA: rsp_ready=0, so the word stalls upstream.
- Latency: cmd_valid → ADDR next cycle. Address pop ≥1 cycle later. Minimum write burst = 2+BURST_LEN cycles.
- Address arithmetic: modulo 2**DATA_W; wrap permitted, no error.
- Backpressure: req_valid and its payload stay stable until req_ready. In WR_DATA, payload changes only after a pop.
- Simultaneous: wfifo_full rising in the same cycle as rsp_valid → no push that cycle. rfifo_empty with req_ready → no handshake.
- Reset mid-burst: return to IDLE next edge, all strobes low. Partially transferred data is abandoned; PCI side is reset by the same sequence.

Decomposition:
- Package pci_sys_pkg: command code constants (CMD_MEM_RD, CMD_MEM_WR), state enum (IDLE, ADDR, WR_DATA, RD_REQ, RD_DATA), DATA_W default.
- Single flat module; no sub-module. Datapath is pass-through muxing plus one counter and one address register.

Test Plan:
- Write burst: cmd_valid, cmd=0111, rfifo holds 0x1000 then 8 data words, req_ready=1 → 8 write beats, addrs 0x1000..0x101C, data in order, 9 pops total, busy low after last beat.
- Write backpressure: same stimulus, req_ready toggling 1/0 and rfifo going empty mid-burst → no duplicated or lost beats, rfifo_pop only on handshake cycles.
- Read burst: cmd=0110, address 0x2000, req_ready delayed 3 cycles, then 8 rsp words A0..A7 with wfifo_full pulsed twice → one read request at 0x2000, wfifo receives A0..A7 in order, rsp_ready=0 during full.
- Unsupported: cmd=0011 followed by cmd=1111 → each pops one word, no req_valid, bad_cmd_cnt=2. 300 bad commands → bad_cmd_cnt=255.
- Reset mid-read after 3 pushes: sys_rst_n low one cycle → next edge all outputs 0, state IDLE. A new MEM_WR completes normally.
- Address wrap: base 0xFFFFFFF8 write → beat addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, … 0x14.
